// File: rtl/find_collector_if.sv
// Bus between the find cores / downstream consumer and find_collector.
// master drives the core results and handshake inputs; slave is the collector itself.
interface find_collector_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_WIDTH = 2,
    parameter int unsigned SEQ_WIDTH = 8,
    parameter int unsigned E_WIDTH   = 20
);
    logic [NUM_CORES*SEQ_WIDTH-1:0] i_seq;
    logic [NUM_CORES*E_WIDTH-1:0]   i_e;
    logic [NUM_CORES-1:0]           i_done;
    logic                           i_clear;
    logic                           i_ready;
    logic [SEQ_WIDTH-1:0]           o_seq;
    logic [E_WIDTH-1:0]             o_e;
    logic [IDX_WIDTH-1:0]           o_idx;
    logic                           o_valid;
    logic                           o_done;
    logic                           o_timeout;

    modport master (
        output i_seq, i_e, i_done, i_clear, i_ready,
        input  o_seq, o_e, o_idx, o_valid, o_done, o_timeout
    );

    modport slave (
        input  i_seq, i_e, i_done, i_clear, i_ready,
        output o_seq, o_e, o_idx, o_valid, o_done, o_timeout
    );
endinterface

// File: rtl/find_collector.sv
// Snapshots each find core's result on its done flag, serially scans for the minimum energy
// and presents the winner on a valid/ready handshake. FIND_COLLECTOR_TIMEOUT_EN enables a watchdog.
module find_collector #(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned IDX_WIDTH      = 2,
    parameter int unsigned SEQ_WIDTH      = 8,
    parameter int unsigned E_WIDTH        = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic               clk,
    input  logic               rst_n,
    find_collector_if.slave    bus
);
    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [NUM_CORES-1:0] captured_q;
    logic [SEQ_WIDTH-1:0] seq_slot_q [NUM_CORES];
    logic [E_WIDTH-1:0]   e_slot_q   [NUM_CORES];
    logic [IDX_WIDTH-1:0] scan_idx_q;
    logic [SEQ_WIDTH-1:0] best_seq_q;
    logic [E_WIDTH-1:0]   best_e_q;
    logic [IDX_WIDTH-1:0] best_idx_q;
    logic                 best_vld_q;
    logic                 timed_out_q;
    logic [SEQ_WIDTH-1:0] o_seq_q;
    logic [E_WIDTH-1:0]   o_e_q;
    logic [IDX_WIDTH-1:0] o_idx_q;
    logic                 o_valid_q, o_done_q, o_timeout_q;

    logic                 all_captured_c, last_idx_c, take_c, timeout_hit_c;
    logic [SEQ_WIDTH-1:0] cand_seq_c;
    logic [E_WIDTH-1:0]   cand_e_c;
    logic [IDX_WIDTH-1:0] cand_idx_c;

    assign all_captured_c = &captured_q;
    assign last_idx_c     = (scan_idx_q == IDX_WIDTH'(NUM_CORES - 1));

`ifdef FIND_COLLECTOR_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    assign timeout_hit_c = (state_q == ST_WAIT) && !all_captured_c &&
                           (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts WAIT cycles since reset or the last clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (bus.i_clear) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_WAIT && !timeout_hit_c) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    assign timeout_hit_c = 1'b0;
`endif

    // Scan candidate: uncaptured slots are skipped, ties keep the earlier index
    always_comb begin
        take_c     = 1'b0;
        cand_seq_c = best_seq_q;
        cand_e_c   = best_e_q;
        cand_idx_c = best_idx_q;
        if (captured_q[scan_idx_q] && (!best_vld_q || e_slot_q[scan_idx_q] < best_e_q)) begin
            take_c     = 1'b1;
            cand_seq_c = seq_slot_q[scan_idx_q];
            cand_e_c   = e_slot_q[scan_idx_q];
            cand_idx_c = scan_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_WAIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.i_clear) begin
            state_d = ST_WAIT;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (all_captured_c)     state_d = ST_SCAN;
                    else if (timeout_hit_c) state_d = (|captured_q) ? ST_SCAN : ST_VALID;
                end
                ST_SCAN:  if (last_idx_c) state_d = ST_VALID;
                ST_VALID: if (bus.i_ready) state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    // Capture is only open in WAIT and closes at the watchdog edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured_q <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                seq_slot_q[k] <= '0;
                e_slot_q[k]   <= '0;
            end
        end else if (bus.i_clear) begin
            captured_q <= '0;
        end else if (state_q == ST_WAIT && !timeout_hit_c) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (bus.i_done[k] && !captured_q[k]) begin
                    captured_q[k] <= 1'b1;
                    seq_slot_q[k] <= bus.i_seq[k*SEQ_WIDTH +: SEQ_WIDTH];
                    e_slot_q[k]   <= bus.i_e[k*E_WIDTH +: E_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx_q  <= '0;
            best_seq_q  <= '0;
            best_e_q    <= '0;
            best_idx_q  <= '0;
            best_vld_q  <= 1'b0;
            timed_out_q <= 1'b0;
            o_seq_q     <= '0;
            o_e_q       <= '0;
            o_idx_q     <= '0;
            o_valid_q   <= 1'b0;
            o_done_q    <= 1'b0;
            o_timeout_q <= 1'b0;
        end else if (bus.i_clear) begin
            scan_idx_q  <= '0;
            best_vld_q  <= 1'b0;
            timed_out_q <= 1'b0;
            o_seq_q     <= '0;
            o_e_q       <= '0;
            o_idx_q     <= '0;
            o_valid_q   <= 1'b0;
            o_done_q    <= 1'b0;
            o_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    scan_idx_q <= '0;
                    best_vld_q <= 1'b0;
                    if (timeout_hit_c) begin
                        timed_out_q <= 1'b1;
                        // Nothing captured: report the empty result directly
                        if (!(|captured_q)) begin
                            o_seq_q     <= '0;
                            o_e_q       <= '1;
                            o_idx_q     <= '0;
                            o_valid_q   <= 1'b1;
                            o_timeout_q <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    best_seq_q <= cand_seq_c;
                    best_e_q   <= cand_e_c;
                    best_idx_q <= cand_idx_c;
                    best_vld_q <= best_vld_q | take_c;
                    scan_idx_q <= scan_idx_q + IDX_WIDTH'(1);
                    if (last_idx_c) begin
                        o_seq_q     <= cand_seq_c;
                        o_e_q       <= cand_e_c;
                        o_idx_q     <= cand_idx_c;
                        o_valid_q   <= 1'b1;
                        o_timeout_q <= timed_out_q;
                    end
                end
                ST_VALID: begin
                    if (bus.i_ready) begin
                        o_valid_q <= 1'b0;
                        o_done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_seq     = o_seq_q;
    assign bus.o_e       = o_e_q;
    assign bus.o_idx     = o_idx_q;
    assign bus.o_valid   = o_valid_q;
    assign bus.o_done    = o_done_q;
    assign bus.o_timeout = o_timeout_q;
endmodule
